// File: rtl/bitty_sequencer_if.sv
// Sequencer-side bundle: start/stop control, instruction memory read port,
// core issue handshake and status. master = sequencer, slave = environment.
interface bitty_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              stop;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic [15:0]       instruction;
   logic              run;
   logic              done;
   logic [ADDR_W-1:0] pc;
   logic [15:0]       instr_count;
   logic              busy;
   logic              halted;
   logic              error;

   modport master (
      input  start, stop, mem_rdata, done,
      output mem_rd_en, mem_addr, instruction, run, pc, instr_count, busy, halted, error
   );

   modport slave (
      output start, stop, mem_rdata, done,
      input  mem_rd_en, mem_addr, instruction, run, pc, instr_count, busy, halted, error
   );
endinterface

// File: rtl/bitty_sequencer.sv
// Fetch/issue sequencer: 3 cycles start-to-run, then waits on done; stop only takes effect at an
// instruction boundary, a hung core trips the watchdog. BITTY_SEQ_HALT_EN makes 16'hFFFF a halt word.
module bitty_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   bitty_sequencer_if.master bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ISSUE,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [15:0]       count_q, count_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              stop_pend_q, stop_pend_d;
   logic              halted_q, halted_d;
   logic              error_q, error_d;
   logic              run_q, run_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              is_halt;

`ifdef BITTY_SEQ_HALT_EN
   assign is_halt = (bus.mem_rdata == 16'hFFFF);
`else
   assign is_halt = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      count_d     = count_q;
      wd_d        = wd_q;
      stop_pend_d = stop_pend_q;
      halted_d    = halted_q;
      error_d     = error_q;

      if (state_q != S_IDLE && bus.stop) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d     = S_FETCH;
               halted_d    = 1'b0;
               error_d     = 1'b0;
               stop_pend_d = 1'b0;
            end
         end
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            // A halt word is dropped and the PC keeps pointing at it, so a restart halts again.
            if (is_halt) begin
               halted_d    = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               instr_d = bus.mem_rdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done takes priority over a watchdog expiring in the same cycle.
            if (bus.done) begin
               pc_d    = pc_q + ADDR_W'(1);
               count_d = count_q + 16'd1;
               if (stop_pend_q || bus.stop) begin
                  stop_pend_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               error_d     = 1'b1;
               stop_pend_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered alongside it.
      run_d   = (state_d == S_ISSUE);
      rd_en_d = (state_d == S_FETCH);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         instr_q     <= 16'h0000;
         count_q     <= 16'h0000;
         wd_q        <= '0;
         stop_pend_q <= 1'b0;
         halted_q    <= 1'b0;
         error_q     <= 1'b0;
         run_q       <= 1'b0;
         rd_en_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         count_q     <= count_d;
         wd_q        <= wd_d;
         stop_pend_q <= stop_pend_d;
         halted_q    <= halted_d;
         error_q     <= error_d;
         run_q       <= run_d;
         rd_en_q     <= rd_en_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_rd_en   = rd_en_q;
   assign bus.mem_addr    = pc_q;
   assign bus.instruction = instr_q;
   assign bus.run         = run_q;
   assign bus.pc          = pc_q;
   assign bus.instr_count = count_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.error       = error_q;
endmodule

// File: tb/tb_bitty_sequencer.sv
// Bench for bitty_sequencer: main instance (ADDR_W=8, TIMEOUT=64) plus a 2-bit-address
// instance for PC wrap; respects BITTY_SEQ_HALT_EN when it is defined.
module tb_bitty_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bitty_sequencer_if #(.ADDR_W(8)) if1 ();
   bitty_sequencer_if #(.ADDR_W(2)) if2 ();

   bitty_sequencer #(.ADDR_W(8), .TIMEOUT(64)) u1 (.clk(clk), .reset(reset), .bus(if1.master));
   bitty_sequencer #(.ADDR_W(2), .TIMEOUT(8))  u2 (.clk(clk), .reset(reset), .bus(if2.master));

   logic [15:0] mem1 [256];
   logic [15:0] mem2 [4];
   always @(posedge clk) if (if1.mem_rd_en) if1.mem_rdata <= mem1[if1.mem_addr];
   always @(posedge clk) if (if2.mem_rd_en) if2.mem_rdata <= mem2[if2.mem_addr];

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: every done the core hands back retires the instruction at the PC.
   logic [7:0]  m_pc  = 8'd0;
   logic [15:0] m_cnt = 16'd0;
   always @(posedge clk) begin
      if (reset) begin
         m_pc  <= 8'd0;
         m_cnt <= 16'd0;
      end else if (if1.done) begin
         m_pc  <= m_pc + 8'd1;
         m_cnt <= m_cnt + 16'd1;
      end
   end

   // Core model: answers each run with done core_lat cycles later.
   bit core_auto = 1'b1;
   int core_lat  = 2;
   initial begin
      if1.done = 1'b0;
      forever begin
         @(negedge clk);
         if (core_auto && if1.run) begin
            repeat (core_lat) @(negedge clk);
            if1.done = 1'b1;
            @(posedge clk);
            #1 if1.done = 1'b0;
         end
      end
   end

   bit          cmp_en = 1'b0;
   logic        prev_run = 1'b0;
   logic [15:0] issued [$];
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("pc_vs_model", if1.pc, m_pc);
         chk("count_vs_model", if1.instr_count, m_cnt);
         if (if1.mem_rd_en) chk("fetch_addr", if1.mem_addr, m_pc);
         if (if1.run) begin
            chk("run_instr", if1.instruction, mem1[m_pc]);
            chk("run_one_cycle", prev_run, 1'b0);
            issued.push_back(if1.instruction);
         end
      end
      prev_run <= if1.run;
   end

   task automatic wait_idle(input string name);
      int k = 0;
      while (if1.busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(name, if1.busy, 1'b0);
   endtask

   task automatic wait_run(input string name, input logic [7:0] p);
      int k = 0;
      while (!(if1.run && if1.pc == p) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk(name, if1.run && (if1.pc == p), 1'b1);
   endtask

   task automatic pulse_start();
      @(negedge clk) if1.start = 1'b1;
      @(negedge clk) if1.start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk) if1.stop = 1'b1;
      @(negedge clk) if1.stop = 1'b0;
   endtask

   logic [15:0] exp_basic [4];
   int          wrap_addr [$];
   int          base;
   int          n;

   initial begin
      if1.start = 1'b0;
      if1.stop  = 1'b0;
      if2.start = 1'b0;
      if2.stop  = 1'b0;
      if2.done  = 1'b1;
      for (int i = 0; i < 256; i++) mem1[i] = 16'h0100 + 16'(i);
      mem1[0] = 16'h1111; mem1[1] = 16'h2222; mem1[2] = 16'h3333;
      mem1[3] = 16'h4444; mem1[4] = 16'h5555;
      for (int i = 0; i < 4; i++) mem2[i] = 16'h0A00 + 16'(i);
      exp_basic[0] = 16'h1111; exp_basic[1] = 16'h2222;
      exp_basic[2] = 16'h3333; exp_basic[3] = 16'h4444;

      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_flags", {if1.run, if1.mem_rd_en, if1.busy, if1.halted, if1.error}, 5'b0);
      chk("rst_pc", if1.pc, 8'd0);
      chk("rst_addr", if1.mem_addr, 8'd0);
      chk("rst_instr", if1.instruction, 16'h0000);
      chk("rst_count", if1.instr_count, 16'd0);
      cmp_en = 1'b1;

      // Basic run: start at edge 0, FETCH in 1, LATCH in 2, run in 3.
      pulse_start();
      chk("c1_rd_en", if1.mem_rd_en, 1'b1);
      chk("c1_addr", if1.mem_addr, 8'd0);
      chk("c1_busy", if1.busy, 1'b1);
      @(negedge clk);
      chk("c2_no_run", if1.run, 1'b0);
      @(negedge clk);
      chk("c3_run", if1.run, 1'b1);
      chk("c3_instr", if1.instruction, 16'h1111);

      // Stop raised during WAIT_DONE of the instruction at pc 2.
      wait_run("reach_pc2", 8'd2);
      pulse_stop();
      wait_idle("stop_idle");
      chk("stop_pc", if1.pc, 8'd3);
      chk("stop_count", if1.instr_count, 16'd3);
      pulse_start();
      chk("resume_addr", if1.mem_addr, 8'd3);
      chk("resume_rd_en", if1.mem_rd_en, 1'b1);
      wait_run("reach_pc3", 8'd3);
      pulse_stop();
      wait_idle("stop2_idle");
      chk("basic_count", if1.instr_count, 16'd4);
      chk("basic_issued_n", issued.size(), 4);
      for (int i = 0; i < 4; i++) chk("basic_seq", issued[i], exp_basic[i]);

      // Timeout: core silent, error appears 64 WAIT_DONE cycles after run.
      core_auto = 1'b0;
      pulse_start();
      wait_run("to_run", 8'd4);
      n = 0;
      while (!if1.error && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", n, 65);
      chk("to_busy", if1.busy, 1'b0);
      chk("to_pc", if1.pc, 8'd4);
      chk("to_count", if1.instr_count, 16'd4);
      pulse_start();
      chk("to_err_clear", if1.error, 1'b0);
      chk("to_restart_busy", if1.busy, 1'b1);

      // Asynchronous reset while waiting on the core.
      wait_run("rst_run", 8'd4);
      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_flags", {if1.run, if1.busy, if1.mem_rd_en}, 3'b0);
      chk("arst_pc", if1.pc, 8'd0);
      @(negedge clk) reset = 1'b0;
      @(negedge clk) cmp_en = 1'b1;

      // Halt word at address 2.
      mem1[0] = 16'hA0A0; mem1[1] = 16'hB0B0; mem1[2] = 16'hFFFF; mem1[3] = 16'hC0C0;
      core_auto = 1'b1;
      core_lat  = 1;
      base = issued.size();
      pulse_start();
`ifdef BITTY_SEQ_HALT_EN
      wait_idle("halt_idle");
      chk("halt_runs", issued.size() - base, 2);
      chk("halt_flag", if1.halted, 1'b1);
      chk("halt_pc", if1.pc, 8'd2);
      pulse_start();
      chk("halt_restart_flag", if1.halted, 1'b0);
      wait_idle("halt2_idle");
      chk("halt2_flag", if1.halted, 1'b1);
      chk("halt2_pc", if1.pc, 8'd2);
      chk("halt2_runs", issued.size() - base, 2);
`else
      wait_run("ffff_run", 8'd2);
      chk("ffff_instr", if1.instruction, 16'hFFFF);
      chk("ffff_halted", if1.halted, 1'b0);
      pulse_stop();
      wait_idle("ffff_idle");
      chk("ffff_pc", if1.pc, 8'd3);
      chk("ffff_runs", issued.size() - base, 3);
`endif

      // PC wrap on the 2-bit instance; its core answers done immediately.
      @(negedge clk) if2.start = 1'b1;
      @(negedge clk) if2.start = 1'b0;
      n = 0;
      if (if2.mem_rd_en) wrap_addr.push_back(int'(if2.mem_addr));
      while (wrap_addr.size() < 5 && n < 100) begin
         @(negedge clk);
         n++;
         if (if2.mem_rd_en) wrap_addr.push_back(int'(if2.mem_addr));
      end
      @(negedge clk) if2.stop = 1'b1;
      @(negedge clk) if2.stop = 1'b0;
      n = 0;
      while (if2.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_idle", if2.busy, 1'b0);
      chk("wrap_n", wrap_addr.size(), 5);
      for (int i = 0; i < 5 && i < wrap_addr.size(); i++) chk("wrap_addr", wrap_addr[i], i % 4);
      chk("wrap_count", if2.instr_count, 16'd5);
      chk("wrap_pc", if2.pc, 2'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
